// File: rtl/pll_reset_sequencer_if.sv
// Control and status bundle between the PLL reset sequencer and the clock subsystem.
// The master side is the sequencer; the slave side is whoever pulses restart and watches status.
interface pll_reset_sequencer_if;
    logic       restart_req;
    logic       clk_heartbeat;
    logic       pll_reset;
    logic       rst0_out;
    logic       rst1_out;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;

    modport master (
        input  restart_req,
        input  clk_heartbeat,
        output pll_reset,
        output rst0_out,
        output rst1_out,
        output ready,
        output fault,
        output retry_cnt
    );

    modport slave (
        output restart_req,
        output clk_heartbeat,
        input  pll_reset,
        input  rst0_out,
        input  rst1_out,
        input  ready,
        input  fault,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Brings up the system PLL from refclk: hold, settle, heartbeat check, staged domain reset
// release, then heartbeat watchdog with bounded retries before latching a fault.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_HOLD   | pll_reset held high for HOLD_CYCLES
//   ST_SETTLE | PLL released, VCO settling, heartbeat ignored
//   ST_CHECK  | count HB_EDGES heartbeat edges within WDOG_CYCLES
//   ST_REL0   | clk0 domain released, clk1 held for RELEASE_GAP
//   ST_RUN    | both domains released, heartbeat watchdog armed
//   ST_FAULT  | retries exhausted, everything held in reset
module pll_reset_sequencer #(
    parameter int HOLD_CYCLES   = 64,
    parameter int SETTLE_CYCLES = 5000,
    parameter int HB_EDGES      = 4,
    parameter int WDOG_CYCLES   = 256,
    parameter int RELEASE_GAP   = 16,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic                  refclk,
    input  logic                  reset,
    pll_reset_sequencer_if.master seq
);

    localparam int EDGE_W = $clog2(HB_EDGES + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WDOG_LAST   = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
    localparam logic [EDGE_W-1:0] EDGE_TARGET = EDGE_W'(HB_EDGES);
    localparam logic [1:0]        RETRY_LIMIT = 2'((MAX_RETRY > 3) ? 3 : MAX_RETRY);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SETTLE,
        ST_CHECK,
        ST_REL0,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [1:0]        retry_q, retry_d;

    logic              hb_s1_q, hb_s2_q, hb_s3_q;

    logic              pll_reset_q, pll_reset_d;
    logic              rst0_q, rst0_d;
    logic              rst1_q, rst1_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;

    logic              hb_edge;
    logic [EDGE_W-1:0] edges_seen;
    logic              fail;

    assign hb_edge    = hb_s2_q ^ hb_s3_q;
    assign edges_seen = edge_cnt_q + EDGE_W'(hb_edge);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        edge_cnt_d = '0;
        retry_d    = retry_q;
        fail       = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // an edge landing on the last window cycle still counts
                if (edges_seen == EDGE_TARGET) begin
                    state_d = ST_REL0;
                end else if (cnt_q == WDOG_LAST) begin
                    fail = 1'b1;
                end else begin
                    edge_cnt_d = edges_seen;
                end
            end
            ST_REL0: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hb_edge) begin
                    cnt_d = '0;
                end else if (cnt_q == WDOG_LAST) begin
                    fail = 1'b1;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (fail) begin
            if (retry_q == RETRY_LIMIT) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_HOLD;
                if (retry_q != 2'd3) begin
                    retry_d = retry_q + 2'd1;
                end
            end
        end

        // restart overrides any same-cycle completion or failure
        if (seq.restart_req) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end

        if ((state_d != state_q) || seq.restart_req) begin
            cnt_d      = '0;
            edge_cnt_d = '0;
        end

        pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
        rst0_d      = (state_d != ST_REL0) && (state_d != ST_RUN);
        rst1_d      = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            edge_cnt_q  <= '0;
            retry_q     <= '0;
            hb_s1_q     <= 1'b0;
            hb_s2_q     <= 1'b0;
            hb_s3_q     <= 1'b0;
            pll_reset_q <= 1'b1;
            rst0_q      <= 1'b1;
            rst1_q      <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            retry_q     <= retry_d;
            hb_s1_q     <= seq.clk_heartbeat;
            hb_s2_q     <= hb_s1_q;
            hb_s3_q     <= hb_s2_q;
            pll_reset_q <= pll_reset_d;
            rst0_q      <= rst0_d;
            rst1_q      <= rst1_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign seq.pll_reset = pll_reset_q;
    assign seq.rst0_out  = rst0_q;
    assign seq.rst1_out  = rst1_q;
    assign seq.ready     = ready_q;
    assign seq.fault     = fault_q;
    assign seq.retry_cnt = retry_q;

endmodule
